// File: rtl/mat_mul_pkg.sv
// Shared types and helpers for the matrix multiply-accumulate datapath.
package mat_mul_pkg;

    // Working width for saturating adds; accumulators must be narrower than this.
    localparam int SAT_W = 64;

    // Per-stage beat tag carried alongside the datapath.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } beat_tag_t;

    // $clog2 that never returns 0, for sizing arrays that need at least one entry.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Signed add clamped to a w-bit range. Returns {clamped, sum}; the low w bits
    // of sum are the two's-complement result.
    function automatic logic [SAT_W:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int                      w
    );
        logic signed [SAT_W:0] s;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        s  = a + b;
        hi = ((SAT_W+1)'(1) <<< (w - 1)) - (SAT_W+1)'(1);
        lo = -((SAT_W+1)'(1) <<< (w - 1));
        if (s > hi) begin
            return {1'b1, hi[SAT_W-1:0]};
        end else if (s < lo) begin
            return {1'b1, lo[SAT_W-1:0]};
        end else begin
            return {1'b0, s[SAT_W-1:0]};
        end
    endfunction

endpackage

// File: rtl/mat_mul_adder_tree.sv
// Registered pairwise adder tree: sums K signed products into one W_OUT value.
// K is zero-padded up to the next power of two; one register per tree level.
module mat_mul_adder_tree
    import mat_mul_pkg::*;
#(
    parameter int W_IN  = 8,
    parameter int W_OUT = 32,
    parameter int K     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [K-1:0][2*W_IN-1:0]     products,
    output logic signed [W_OUT-1:0]      sum
);

    localparam int DEPTH = $clog2(K);
    localparam int PAD   = 1 << DEPTH;
    localparam int LVLS  = clog2_min1(K);

    logic signed [W_OUT-1:0] leaf [PAD];

    for (genvar i = 0; i < PAD; i++) begin : g_leaf
        if (i < K) begin : g_real
            assign leaf[i] = W_OUT'($signed(products[i]));
        end else begin : g_pad
            assign leaf[i] = '0;
        end
    end

    if (DEPTH == 0) begin : g_pass
        // A single product needs no reduction; the product register is the only stage.
        assign sum = leaf[0];
    end else begin : g_tree
        logic signed [W_OUT-1:0] node [LVLS][PAD];

        // Each level halves the operand count; levels advance together with the pipeline.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int d = 0; d < LVLS; d++) begin
                    for (int i = 0; i < PAD; i++) begin
                        node[d][i] <= '0;
                    end
                end
            end else if (en) begin
                for (int i = 0; i < PAD / 2; i++) begin
                    node[0][i] <= leaf[2*i] + leaf[2*i+1];
                end
                for (int d = 1; d < DEPTH; d++) begin
                    for (int i = 0; i < (PAD >> (d + 1)); i++) begin
                        node[d][i] <= node[d-1][2*i] + node[d-1][2*i+1];
                    end
                end
            end
        end

        assign sum = node[DEPTH-1][0];
    end

endmodule

// File: rtl/mat_mul_acc.sv
// Pipelined MxK * KxN signed matrix multiply-accumulate with tile framing,
// saturating accumulation and valid/ready backpressure.
// Pipeline: product register -> DEPTH tree levels -> accumulate/result register.
module mat_mul_acc
    import mat_mul_pkg::*;
#(
    parameter int W_IN  = 8,
    parameter int W_OUT = 32,
    parameter int M     = 2,
    parameter int K     = 2,
    parameter int N     = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cen,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_first,
    input  logic                              in_last,
    input  logic [M-1:0][K-1:0][W_IN-1:0]     matrix_a,
    input  logic [K-1:0][N-1:0][W_IN-1:0]     matrix_b,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [M-1:0][N-1:0][W_OUT-1:0]    result,
    output logic                              overflow
);

    localparam int DEPTH = $clog2(K);

    if (W_OUT < 2*W_IN + DEPTH) begin : g_bad_w_out
        $error("mat_mul_acc: W_OUT too narrow to hold one beat's dot product");
    end
    if (W_OUT >= SAT_W) begin : g_bad_sat_w
        $error("mat_mul_acc: W_OUT must be narrower than the saturation working width");
    end

    logic stall;
    logic adv;
    logic accept;

    assign stall    = out_valid && !out_ready;
    assign adv      = cen && !stall;
    assign in_ready = adv;
    assign accept   = in_valid && in_ready;

    beat_tag_t                            tag_q [DEPTH+1];
    beat_tag_t                            tag_a;
    logic [M-1:0][N-1:0][K-1:0][2*W_IN-1:0] prod_q;
    logic signed [W_OUT-1:0]              tree_sum [M][N];
    logic signed [W_OUT-1:0]              acc      [M][N];
    logic signed [W_OUT-1:0]              acc_nxt  [M][N];
    logic                                 acc_ovf;
    logic                                 ovf_nxt;

    assign tag_a = tag_q[DEPTH];

    // Product stage: unaccepted beats load zeros so idle operands never reach the tree.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
        end else if (adv) begin
            for (int m = 0; m < M; m++) begin
                for (int n = 0; n < N; n++) begin
                    for (int k = 0; k < K; k++) begin
                        if (accept) begin
                            prod_q[m][n][k] <= $signed(matrix_a[m][k]) * $signed(matrix_b[k][n]);
                        end else begin
                            prod_q[m][n][k] <= '0;
                        end
                    end
                end
            end
        end
    end

    // Beat tags shift alongside the product and tree registers, one entry per stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else if (adv) begin
            tag_q[0] <= '{valid: accept, first: accept && in_first, last: accept && in_last};
            for (int i = 1; i <= DEPTH; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    for (genvar m = 0; m < M; m++) begin : g_row
        for (genvar n = 0; n < N; n++) begin : g_col
            mat_mul_adder_tree #(
                .W_IN  (W_IN),
                .W_OUT (W_OUT),
                .K     (K)
            ) u_tree (
                .clk      (clk),
                .rst      (rst),
                .en       (adv),
                .products (prod_q[m][n]),
                .sum      (tree_sum[m][n])
            );
        end
    end

    // Next accumulator value: a first beat replaces, any other beat saturating-adds.
    always_comb begin
        logic [SAT_W:0] sat_r;
        sat_r   = '0;
        ovf_nxt = tag_a.first ? 1'b0 : acc_ovf;
        for (int m = 0; m < M; m++) begin
            for (int n = 0; n < N; n++) begin
                sat_r = sat_add(SAT_W'(acc[m][n]), SAT_W'(tree_sum[m][n]), W_OUT);
                if (tag_a.first) begin
                    acc_nxt[m][n] = tree_sum[m][n];
                end else begin
                    acc_nxt[m][n] = sat_r[W_OUT-1:0];
                    ovf_nxt       = ovf_nxt | sat_r[SAT_W];
                end
            end
        end
    end

    // Accumulate/output stage: a last beat publishes the tile and clears for the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int m = 0; m < M; m++) begin
                for (int n = 0; n < N; n++) begin
                    acc[m][n] <= '0;
                end
            end
            acc_ovf   <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else if (adv) begin
            // Advancing implies any held result is being taken this edge.
            out_valid <= tag_a.valid && tag_a.last;
            if (tag_a.valid) begin
                if (tag_a.last) begin
                    for (int m = 0; m < M; m++) begin
                        for (int n = 0; n < N; n++) begin
                            result[m][n] <= acc_nxt[m][n];
                            acc[m][n]    <= '0;
                        end
                    end
                    overflow <= ovf_nxt;
                    acc_ovf  <= 1'b0;
                end else begin
                    for (int m = 0; m < M; m++) begin
                        for (int n = 0; n < N; n++) begin
                            acc[m][n] <= acc_nxt[m][n];
                        end
                    end
                    acc_ovf <= ovf_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_mat_mul_acc.sv
// Self-checking bench for mat_mul_acc: directed framing/saturation/backpressure
// cases plus randomized traffic against a tile-level arithmetic reference.
module tb_mat_mul_acc;

    localparam int W_IN  = 8;
    localparam int W_OUT = 18;
    localparam int M     = 2;
    localparam int K     = 2;
    localparam int N     = 2;
    localparam longint SAT_HI = (longint'(1) << (W_OUT - 1)) - 1;
    localparam longint SAT_LO = -(longint'(1) << (W_OUT - 1));

    typedef logic [M-1:0][K-1:0][W_IN-1:0]  mat_a_t;
    typedef logic [K-1:0][N-1:0][W_IN-1:0]  mat_b_t;
    typedef logic [M-1:0][N-1:0][W_OUT-1:0] mat_r_t;
    typedef struct packed { logic ovf; mat_r_t res; } exp_t;

    logic   clk;
    logic   rst;
    logic   cen;
    logic   in_valid;
    logic   in_ready;
    logic   in_first;
    logic   in_last;
    mat_a_t matrix_a;
    mat_b_t matrix_b;
    logic   out_valid;
    logic   out_ready;
    mat_r_t result;
    logic   overflow;

    mat_mul_acc #(
        .W_IN (W_IN), .W_OUT (W_OUT), .M (M), .K (K), .N (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_last   (in_last),
        .matrix_a  (matrix_a),
        .matrix_b  (matrix_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input longint got, input longint want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    endtask

    function automatic longint sx(input logic [W_OUT-1:0] v);
        return longint'($signed(v));
    endfunction

    // Reference: whole-tile arithmetic on accepted beats.
    longint m_acc [M][N];
    logic   m_ovf;
    exp_t   exp_q [$];
    exp_t   exp_e;
    mat_r_t last_res;
    logic   last_ovf;
    int     n_out = 0;
    int     out_times [$];

    function automatic void model_clear();
        for (int m = 0; m < M; m++)
            for (int n = 0; n < N; n++)
                m_acc[m][n] = 0;
        m_ovf = 1'b0;
    endfunction

    function automatic void model_beat(input mat_a_t a, input mat_b_t b, input logic first, input logic last);
        exp_t   e;
        longint s;
        longint t;
        if (first) m_ovf = 1'b0;
        for (int m = 0; m < M; m++) begin
            for (int n = 0; n < N; n++) begin
                s = 0;
                for (int k = 0; k < K; k++)
                    s += longint'($signed(a[m][k])) * longint'($signed(b[k][n]));
                if (first) begin
                    m_acc[m][n] = s;
                end else begin
                    t = m_acc[m][n] + s;
                    if (t > SAT_HI) begin t = SAT_HI; m_ovf = 1'b1; end
                    else if (t < SAT_LO) begin t = SAT_LO; m_ovf = 1'b1; end
                    m_acc[m][n] = t;
                end
            end
        end
        if (last) begin
            for (int m = 0; m < M; m++)
                for (int n = 0; n < N; n++)
                    e.res[m][n] = W_OUT'(m_acc[m][n]);
            e.ovf = m_ovf;
            exp_q.push_back(e);
            model_clear();
        end
    endfunction

    // Monitor on the falling edge: score delivered results, feed accepted beats to the model.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_clear();
        end else begin
            if (cen && out_valid && out_ready) begin
                n_out++;
                out_times.push_back(cyc_cnt);
                last_res = result;
                last_ovf = overflow;
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    exp_e = exp_q.pop_front();
                    for (int m = 0; m < M; m++)
                        for (int n = 0; n < N; n++)
                            chk("res", sx(result[m][n]), sx(exp_e.res[m][n]));
                    chk("ovf", longint'(overflow), longint'(exp_e.ovf));
                end
            end
            if (in_valid && in_ready) model_beat(matrix_a, matrix_b, in_first, in_last);
        end
    end

    function automatic mat_a_t fill_a(input int v);
        mat_a_t r;
        for (int m = 0; m < M; m++) for (int k = 0; k < K; k++) r[m][k] = W_IN'(v);
        return r;
    endfunction

    function automatic mat_b_t fill_b(input int v);
        mat_b_t r;
        for (int k = 0; k < K; k++) for (int n = 0; n < N; n++) r[k][n] = W_IN'(v);
        return r;
    endfunction

    function automatic mat_a_t ident_a();
        mat_a_t r;
        for (int m = 0; m < M; m++) for (int k = 0; k < K; k++) r[m][k] = (m == k) ? W_IN'(1) : W_IN'(0);
        return r;
    endfunction

    function automatic mat_a_t rand_a(input logic extreme);
        mat_a_t r;
        for (int m = 0; m < M; m++) for (int k = 0; k < K; k++) r[m][k] = extreme ? W_IN'(-128) : W_IN'($urandom);
        return r;
    endfunction

    function automatic mat_b_t rand_b(input logic extreme, input logic neg);
        mat_b_t r;
        for (int k = 0; k < K; k++) for (int n = 0; n < N; n++)
            r[k][n] = extreme ? (neg ? W_IN'(-128) : W_IN'(127)) : W_IN'($urandom);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input mat_a_t a, input mat_b_t b, input logic f, input logic l);
        int   waited;
        logic took;
        waited   = 0;
        took     = 1'b0;
        in_valid = 1'b1;
        matrix_a = a;
        matrix_b = b;
        in_first = f;
        in_last  = l;
        while (!took && waited < 200) begin
            @(negedge clk);
            took = in_ready;
            tick();
            waited++;
        end
        if (!took) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 200) begin
            tick();
            w++;
        end
        chk("drain_done", longint'(w < 200), 1);
    endtask

    task automatic chk_last_all(input string tag, input longint v, input logic ovf);
        for (int m = 0; m < M; m++)
            for (int n = 0; n < N; n++)
                chk(tag, sx(last_res[m][n]), v);
        chk({tag, "_ovf"}, longint'(last_ovf), longint'(ovf));
    endtask

    mat_a_t bp_a [5];
    mat_b_t bp_b [5];
    int     ref_off [5];
    int     t0;
    int     base;
    int     outs0;
    logic   rand_done;
    logic   saw_in_ready_low;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Reset with a live beat on the inputs: nothing may come out of it.
        rst       = 1'b1;
        cen       = 1'b1;
        in_valid  = 1'b1;
        in_first  = 1'b1;
        in_last   = 1'b1;
        matrix_a  = fill_a(5);
        matrix_b  = fill_b(5);
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_overflow", longint'(overflow), 0);
        for (int m = 0; m < M; m++)
            for (int n = 0; n < N; n++)
                chk("rst_result", sx(result[m][n]), 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("in_ready_after_rst", longint'(in_ready), 1);
        repeat (4) tick();
        chk("idle_out_valid", longint'(out_valid), 0);

        // Single beat, latency c+3 for K=2.
        matrix_a = '0;
        matrix_b = '0;
        begin
            mat_a_t a;
            mat_b_t b;
            a[0][0] = 8'sd1; a[0][1] = 8'sd2; a[1][0] = 8'sd3; a[1][1] = 8'sd4;
            b[0][0] = 8'sd5; b[0][1] = 8'sd6; b[1][0] = 8'sd7; b[1][1] = 8'sd8;
            send(a, b, 1'b1, 1'b1);
        end
        chk("lat_c+1", longint'(out_valid), 0);
        tick();
        chk("lat_c+2", longint'(out_valid), 0);
        tick();
        chk("lat_c+3", longint'(out_valid), 1);
        chk("single_r00", sx(result[0][0]), 19);
        chk("single_r01", sx(result[0][1]), 22);
        chk("single_r10", sx(result[1][0]), 43);
        chk("single_r11", sx(result[1][1]), 50);
        chk("single_ovf", longint'(overflow), 0);
        drain();

        // Three-beat tile: I*1 + I*2 + I*(-1) -> all 2, exactly one output.
        outs0 = n_out;
        send(ident_a(), fill_b(1), 1'b1, 1'b0);
        send(ident_a(), fill_b(2), 1'b0, 1'b0);
        send(ident_a(), fill_b(-1), 1'b0, 1'b1);
        drain();
        chk("accum_out_count", n_out - outs0, 1);
        chk_last_all("accum", 2, 1'b0);

        // Saturation: four beats of 32768 per element clamp at 131071.
        send(fill_a(-128), fill_b(-128), 1'b1, 1'b0);
        send(fill_a(-128), fill_b(-128), 1'b0, 1'b0);
        send(fill_a(-128), fill_b(-128), 1'b0, 1'b0);
        send(fill_a(-128), fill_b(-128), 1'b0, 1'b1);
        drain();
        chk_last_all("sat", 131071, 1'b1);
        send(fill_a(0), fill_b(0), 1'b1, 1'b1);
        drain();
        chk_last_all("after_sat", 0, 1'b0);

        // Framing: in_first mid-tile discards the partial.
        send(fill_a(1), fill_b(1), 1'b1, 1'b0);
        send(fill_a(3), fill_b(3), 1'b1, 1'b1);
        drain();
        chk_last_all("restart", 18, 1'b0);

        // Reset mid-tile, then a closing beat that must not see the old partial.
        send(fill_a(7), fill_b(7), 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send(fill_a(2), fill_b(2), 1'b0, 1'b1);
        drain();
        chk_last_all("post_rst", 8, 1'b0);

        // Reference timing for five back-to-back single-beat tiles.
        for (int i = 0; i < 5; i++) begin
            bp_a[i] = rand_a(1'b0);
            bp_b[i] = rand_b(1'b0, 1'b0);
        end
        t0   = cyc_cnt;
        base = out_times.size();
        for (int i = 0; i < 5; i++) send(bp_a[i], bp_b[i], 1'b1, 1'b1);
        drain();
        chk("ref_count", out_times.size() - base, 5);
        for (int i = 0; i < 5; i++) ref_off[i] = (base + i < out_times.size()) ? out_times[base + i] - t0 : -1;

        // Same tiles with cen low for 3 cycles: outputs identical, shifted by 3.
        t0   = cyc_cnt;
        base = out_times.size();
        for (int i = 0; i < 5; i++) begin
            send(bp_a[i], bp_b[i], 1'b1, 1'b1);
            if (i == 1) begin
                cen = 1'b0;
                repeat (3) tick();
                cen = 1'b1;
            end
        end
        drain();
        chk("cen_count", out_times.size() - base, 5);
        for (int i = 0; i < 5; i++)
            if (base + i < out_times.size())
                chk("cen_delay", out_times[base + i] - t0, ref_off[i] + 3);

        // Backpressure: hold out_ready low for 4 cycles once a result is waiting.
        outs0            = n_out;
        saw_in_ready_low = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) send(rand_a(1'b0), rand_b(1'b0, 1'b0), 1'b1, 1'b1);
            end
            begin
                int w;
                w         = 0;
                out_ready = 1'b0;
                while (!out_valid && w < 50) begin tick(); w++; end
                chk("bp_out_valid_seen", longint'(out_valid), 1);
                repeat (4) begin
                    if (!in_ready) saw_in_ready_low = 1'b1;
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_in_ready_dropped", longint'(saw_in_ready_low), 1);
        chk("bp_out_count", n_out - outs0, 5);

        // Randomized traffic with bubbles, backpressure and clock-enable gaps.
        outs0     = n_out;
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic ext;
                    ext = ($urandom_range(0, 2) == 0);
                    send(rand_a(ext), rand_b(ext, $urandom_range(0, 1) == 1),
                         $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
                    if ($urandom_range(0, 3) == 0) tick();
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    cen       = ($urandom_range(0, 15) != 0);
                    tick();
                end
                out_ready = 1'b1;
                cen       = 1'b1;
            end
        join
        send(rand_a(1'b0), rand_b(1'b0, 1'b0), 1'b0, 1'b1);
        drain();
        chk("rand_outputs_seen", longint'(n_out - outs0 > 0), 1);
        chk("rand_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
